// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, optional parity,
// 1 or 2 stop bits, and an input FIFO that feeds back-to-back frames.
module uart_tx_param #(
    parameter int FREQUENCY  = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT * 2) + 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int FCNT_W       = PTR_W + 1;
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam bit HAS_PARITY   = (PARITY != 0);

    localparam logic [CNT_W-1:0]  BIT_LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST_CNT = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST_IDX = BIT_W'(DATA_BITS - 1);
    localparam logic [FCNT_W-1:0] DEPTH_CNT     = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for a popped word; zero when parity is disabled.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        logic p;
        case (PARITY)
            32'sd1:  p = ~^d;
            32'sd2:  p = ^d;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     clk_cnt_r, clk_cnt_s;
    logic [BIT_W-1:0]     bit_idx_r, bit_idx_s;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parity_r;
    logic                 line_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 empty_s;
    logic                 stop_last_s;
    logic                 stop_last_r;
    logic                 tx_serial_r;
    logic                 tx_active_r;
    logic                 tx_done_r;
    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [FCNT_W-1:0]    count_r;

    // Ready looks only at the current count, never at a same-cycle pop.
    assign tx_ready   = (count_r < DEPTH_CNT);
    assign push_s     = tx_valid & tx_ready;
    assign empty_s    = (count_r == {FCNT_W{1'b0}});
    assign tx_serial  = tx_serial_r;
    assign tx_active  = tx_active_r;
    assign tx_done    = tx_done_r;
    assign fifo_count = count_r;

    // Next-state, bit timing and line value for the frame FSM.
    always_comb begin
        state_s     = state_r;
        clk_cnt_s   = clk_cnt_r + CNT_W'(1);
        bit_idx_s   = bit_idx_r;
        pop_s       = 1'b0;
        stop_last_s = 1'b0;
        line_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                clk_cnt_s = {CNT_W{1'b0}};
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                line_s = 1'b0;
                if (clk_cnt_r == BIT_LAST_CNT) begin
                    clk_cnt_s = {CNT_W{1'b0}};
                    bit_idx_s = {BIT_W{1'b0}};
                    state_s   = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                line_s = shift_r[bit_idx_r];
                if (clk_cnt_r == BIT_LAST_CNT) begin
                    clk_cnt_s = {CNT_W{1'b0}};
                    if (bit_idx_r == DATA_LAST_IDX) begin
                        state_s = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + BIT_W'(1);
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                line_s = parity_r;
                if (clk_cnt_r == BIT_LAST_CNT) begin
                    clk_cnt_s = {CNT_W{1'b0}};
                    state_s   = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                line_s = 1'b1;
                if (clk_cnt_r == STOP_LAST_CNT) begin
                    clk_cnt_s   = {CNT_W{1'b0}};
                    stop_last_s = 1'b1;
                    // Chain straight into the next frame when a word is waiting.
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                clk_cnt_s = {CNT_W{1'b0}};
                bit_idx_s = {BIT_W{1'b0}};
                line_s    = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame datapath; outputs trail the state by one cycle so all line timing stays aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_cnt_r   <= {CNT_W{1'b0}};
            bit_idx_r   <= {BIT_W{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            parity_r    <= 1'b0;
            stop_last_r <= 1'b0;
            tx_serial_r <= 1'b1;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            clk_cnt_r   <= clk_cnt_s;
            bit_idx_r   <= bit_idx_s;
            stop_last_r <= stop_last_s;
            tx_serial_r <= line_s;
            tx_active_r <= (state_r != ST_IDLE);
            tx_done_r   <= stop_last_r;
            if (pop_s) begin
                shift_r  <= mem_r[rd_ptr_r];
                parity_r <= parity_of(mem_r[rd_ptr_r]);
            end
        end
    end

    // FIFO storage; contents need no reset because the count guards every read.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {FCNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + FCNT_W'(1);
                2'b01:   count_r <= count_r - FCNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four configurations at CLKS_PER_BIT=10.
`timescale 1ns/1ps
module tb_uart_tx_param;

    typedef struct {
        int          dut;
        logic [8:0]  data;
        int          nbits;
        logic [12:0] line;
        int          len;
    } frame_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_a [4];
    logic [8:0] data_a  [4];
    logic       ready_a [4];
    logic       serial_a[4];
    logic       active_a[4];
    logic       done_a  [4];
    logic [2:0] count_a [4];

    int checks   = 0;
    int failures = 0;

    logic       rx_en = 1'b0;
    logic [7:0] rx_byte;
    logic [8:0] rx_q[$];

    always #5 clk = ~clk;

    uart_tx_param #(.FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .reset(reset), .tx_valid(valid_a[0]), .tx_data(data_a[0][7:0]), .tx_ready(ready_a[0]),
        .tx_serial(serial_a[0]), .tx_active(active_a[0]), .tx_done(done_a[0]), .fifo_count(count_a[0]));
    uart_tx_param #(.FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
        .clk(clk), .reset(reset), .tx_valid(valid_a[1]), .tx_data(data_a[1][6:0]), .tx_ready(ready_a[1]),
        .tx_serial(serial_a[1]), .tx_active(active_a[1]), .tx_done(done_a[1]), .fifo_count(count_a[1]));
    uart_tx_param #(.FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
        .clk(clk), .reset(reset), .tx_valid(valid_a[2]), .tx_data(data_a[2][6:0]), .tx_ready(ready_a[2]),
        .tx_serial(serial_a[2]), .tx_active(active_a[2]), .tx_done(done_a[2]), .fifo_count(count_a[2]));
    uart_tx_param #(.FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_9n1 (
        .clk(clk), .reset(reset), .tx_valid(valid_a[3]), .tx_data(data_a[3]), .tx_ready(ready_a[3]),
        .tx_serial(serial_a[3]), .tx_active(active_a[3]), .tx_done(done_a[3]), .fifo_count(count_a[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line receiver for the 8N1 instance: stores {stop, data} per frame.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rx_en && serial_a[0] == 1'b0) begin
                repeat (5) @(posedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (10) @(posedge clk); #1;
                    rx_byte[j] = serial_a[0];
                end
                repeat (10) @(posedge clk); #1;
                rx_q.push_back({serial_a[0], rx_byte});
                repeat (4) @(posedge clk);
            end
        end
    end

    // Push one word into an idle instance and check the whole frame on the line.
    task automatic run_frame(input frame_vec_t v);
        int d = v.dut;
        int n_done = 0;
        int done_k = -1;
        @(negedge clk);
        valid_a[d] = 1'b1;
        data_a[d]  = v.data;
        @(posedge clk); #1;
        valid_a[d] = 1'b0;
        check("push_count", 32'(count_a[d]), 32'd1);
        for (int k = 1; k <= v.len + 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check("pre_start_high", 32'(serial_a[d]), 32'd1);
                check("popped_count", 32'(count_a[d]), 32'd0);
            end
            if (k == 2) check("start_fall", 32'(serial_a[d]), 32'd0);
            if (k >= 2 && (k - 2) % 10 == 5 && (k - 2) / 10 < v.nbits)
                check($sformatf("d%0d_line_bit%0d", d, (k - 2) / 10), 32'(serial_a[d]), 32'(v.line[(k - 2) / 10]));
            if (done_a[d]) begin
                n_done++;
                done_k = k;
            end
            if (k == v.len + 1) check("active_in_frame", 32'(active_a[d]), 32'd1);
            if (k == v.len + 2) begin
                check("active_after", 32'(active_a[d]), 32'd0);
                check("idle_high", 32'(serial_a[d]), 32'd1);
            end
        end
        check("done_pulses", 32'(n_done), 32'd1);
        check("done_time", 32'(done_k), 32'(v.len + 2));
        check("ready_after", 32'(ready_a[d]), 32'd1);
    endtask

    // Five back-to-back words into a depth-4 FIFO, a refused push while full,
    // then a push coinciding with a pop at count 3.
    task automatic run_back_to_back();
        logic [8:0] words[7];
        logic       acc;
        logic       got66 = 1'b0;
        int         acc66_r = -1;
        int         n_done = 0;
        int         bad_done = 0;
        int         active_lows = 0;
        words = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066, 9'h077};
        rx_q.delete();
        rx_en = 1'b1;
        for (int r = 0; r <= 710; r++) begin
            if (r < 5) begin
                valid_a[0] = 1'b1; data_a[0] = words[r];
            end else if (!got66) begin
                valid_a[0] = 1'b1; data_a[0] = words[5];
            end else if (r == 301) begin
                valid_a[0] = 1'b1; data_a[0] = words[6];
            end else begin
                valid_a[0] = 1'b0;
            end
            @(negedge clk);
            acc = valid_a[0] & ready_a[0];
            if (r < 5) check($sformatf("b2b_ready_r%0d", r), 32'(ready_a[0]), 32'd1);
            if (r == 5) check("full_ready_low", 32'(ready_a[0]), 32'd0);
            if (r == 301) check("push77_ready", 32'(ready_a[0]), 32'd1);
            @(posedge clk); #1;
            if (acc && r >= 5 && !got66) begin
                got66 = 1'b1;
                acc66_r = r;
            end
            if (r == 4) check("full_count", 32'(count_a[0]), 32'd4);
            if (r == 101) check("full_pop_refused", 32'(count_a[0]), 32'd3);
            if (r == 102) check("held_push_count", 32'(count_a[0]), 32'd4);
            if (r == 301) check("push_pop_at3", 32'(count_a[0]), 32'd3);
            if (r >= 2 && r <= 701 && !active_a[0]) active_lows++;
            if (r == 702) check("b2b_active_end", 32'(active_a[0]), 32'd0);
            if (done_a[0]) begin
                n_done++;
                if (r % 100 != 2) bad_done++;
            end
        end
        valid_a[0] = 1'b0;
        rx_en = 1'b0;
        check("held_push_edge", 32'(acc66_r), 32'd102);
        check("b2b_active_gaps", 32'(active_lows), 32'd0);
        check("b2b_done_count", 32'(n_done), 32'd7);
        check("b2b_done_timing", 32'(bad_done), 32'd0);
        check("b2b_rx_count", 32'(rx_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < rx_q.size(); i++)
            check($sformatf("b2b_rx%0d", i), 32'(rx_q[i]), 32'({1'b1, words[i][7:0]}));
    endtask

    // Reset while data bit 3 of a frame is on the line, with a second word queued.
    task automatic run_reset_mid_frame();
        int n_done = 0;
        int not_idle = 0;
        @(negedge clk);
        valid_a[0] = 1'b1; data_a[0] = 9'h052;
        @(posedge clk); #1;
        data_a[0] = 9'h099;
        @(posedge clk); #1;
        valid_a[0] = 1'b0;
        repeat (44) @(posedge clk); #1;
        check("bit3_before_reset", 32'(serial_a[0]), 32'd0);
        check("queued_before_reset", 32'(count_a[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_serial", 32'(serial_a[0]), 32'd1);
        check("rst_mid_active", 32'(active_a[0]), 32'd0);
        check("rst_mid_count", 32'(count_a[0]), 32'd0);
        check("rst_mid_done", 32'(done_a[0]), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            if (done_a[0]) n_done++;
            if (!serial_a[0] || active_a[0]) not_idle++;
        end
        check("rst_no_done", 32'(n_done), 32'd0);
        check("rst_stays_idle", 32'(not_idle), 32'd0);
    endtask

    frame_vec_t vecs[7];
    frame_vec_t post_vec;

    initial begin
        vecs[0] = '{dut: 0, data: 9'h0A5, nbits: 10, line: 13'({1'b1, 8'hA5, 1'b0}), len: 100};
        vecs[1] = '{dut: 0, data: 9'h03C, nbits: 10, line: 13'({1'b1, 8'h3C, 1'b0}), len: 100};
        vecs[2] = '{dut: 1, data: 9'h003, nbits: 11, line: 13'({2'b11, 1'b1, 7'h03, 1'b0}), len: 110};
        vecs[3] = '{dut: 2, data: 9'h003, nbits: 11, line: 13'({2'b11, 1'b0, 7'h03, 1'b0}), len: 110};
        vecs[4] = '{dut: 1, data: 9'h07F, nbits: 11, line: 13'({2'b11, 1'b0, 7'h7F, 1'b0}), len: 110};
        vecs[5] = '{dut: 3, data: 9'h1FF, nbits: 11, line: 13'({1'b1, 9'h1FF, 1'b0}), len: 110};
        vecs[6] = '{dut: 3, data: 9'h100, nbits: 11, line: 13'({1'b1, 9'h100, 1'b0}), len: 110};
        post_vec = '{dut: 0, data: 9'h0C3, nbits: 10, line: 13'({1'b1, 8'hC3, 1'b0}), len: 100};

        for (int i = 0; i < 4; i++) begin
            valid_a[i] = 1'b0;
            data_a[i]  = 9'h000;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_serial", 32'(serial_a[0]), 32'd1);
        check("rst_active", 32'(active_a[0]), 32'd0);
        check("rst_done", 32'(done_a[0]), 32'd0);
        check("rst_count", 32'(count_a[0]), 32'd0);
        check("rst_ready", 32'(ready_a[0]), 32'd1);
        check("rst_serial_9n1", 32'(serial_a[3]), 32'd1);

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);
        run_back_to_back();
        repeat (5) @(posedge clk);
        run_reset_mid_frame();
        run_frame(post_vec);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
